// File: rtl/vend_arbiter.sv
// ---------------------------------------------------------------------------
// vend_arbiter
//   Two-panel arbiter in front of one shared vending core. A requesting panel
//   is granted the core (round-robin pointer when both ask together). While it
//   holds the grant, its item code, coin code and request are forwarded to the
//   core one cycle late. The grant ends on dispense done, invalid item, or the
//   panel dropping its request. Each transaction ends with a single RELEASE
//   cycle.
//
// Optional feature (macro VEND_ARB_TIMEOUT_EN):
//   A counter tracks SERVE cycles that see no valid coin. When it reaches
//   TIMEOUT, the transaction is aborted and abort pulses for one cycle.
//   When the macro is undefined, there is no counter and abort stays 0.
//
// Parameters:
//   TIMEOUT    SERVE cycles without a valid coin before abort (macro only)
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   req0/1     panel requests
//   item0/1    8-bit item codes
//   coin0/1    5-bit one-hot coin codes (1,2,5,10,20)
//   v_done     core: dispense complete
//   v_no_item  core: invalid item
//   v_item     item code to core
//   v_coin     coin code to core; 00000 when invalid
//   v_disp     dispense request to core
//   gnt0/1     one-hot grant
//   busy       a transaction is in progress
//   abort      one-cycle timeout pulse
// ---------------------------------------------------------------------------
module vend_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] item0,
    input  logic [7:0] item1,
    input  logic [4:0] coin0,
    input  logic [4:0] coin1,
    input  logic       v_done,
    input  logic       v_no_item,
    output logic [7:0] v_item,
    output logic [4:0] v_coin,
    output logic       v_disp,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       abort
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SERVE   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_ptr;      // 0: requester 0 wins a tie
    logic       r_sel;      // index of the granted requester
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_busy;
    logic       r_abort;
    logic       r_disp;
    logic [7:0] r_item;
    logic [4:0] r_coin;

    logic       w_pick1;
    logic [7:0] w_item_new;
    logic [4:0] w_coin_new;
    logic       w_req_g;
    logic [7:0] w_item_g;
    logic [4:0] w_coin_g;
    logic       w_exit;
    logic       w_tmo;

    // A coin code is valid only when exactly one bit is set.
    function automatic logic f_coin_ok(input logic [4:0] c);
        return (c != 5'd0) && ((c & (c - 5'd1)) == 5'd0);
    endfunction

    // Invalid coin codes are dropped rather than forwarded.
    function automatic logic [4:0] f_coin_filt(input logic [4:0] c);
        return f_coin_ok(c) ? c : 5'd0;
    endfunction

    // Requester 1 wins when it is alone or when the pointer favours it.
    assign w_pick1    = req1 & (~req0 | r_ptr);
    assign w_item_new = w_pick1 ? item1 : item0;
    assign w_coin_new = w_pick1 ? coin1 : coin0;

    // Only the granted panel is looked at while busy.
    assign w_req_g  = r_sel ? req1  : req0;
    assign w_item_g = r_sel ? item1 : item0;
    assign w_coin_g = r_sel ? coin1 : coin0;

    // Normal exit conditions take precedence over a timeout abort.
    assign w_exit = v_done | v_no_item | ~w_req_g;

`ifdef VEND_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;

    assign w_tmo = ~f_coin_ok(w_coin_g) && ((32'(r_cnt) + 32'd1) == 32'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst || (r_state != S_SERVE) || f_coin_ok(w_coin_g)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b0;
            r_sel   <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_busy  <= 1'b0;
            r_abort <= 1'b0;
            r_disp  <= 1'b0;
            r_item  <= 8'h00;
            r_coin  <= 5'd0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_disp <= 1'b0;
                    r_coin <= 5'd0;
                    if (req0 | req1) begin
                        r_state <= S_SERVE;
                        r_sel   <= w_pick1;
                        r_gnt0  <= ~w_pick1;
                        r_gnt1  <= w_pick1;
                        r_busy  <= 1'b1;
                        r_item  <= w_item_new;
                        r_coin  <= f_coin_filt(w_coin_new);
                        r_disp  <= 1'b1;
                    end
                end
                S_SERVE: begin
                    if (w_exit | w_tmo) begin
                        r_state <= S_RELEASE;
                        r_disp  <= 1'b0;
                        r_coin  <= 5'd0;
                        r_abort <= w_tmo & ~w_exit;
                    end else begin
                        r_item <= w_item_g;
                        r_coin <= f_coin_filt(w_coin_g);
                        r_disp <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    // Grant was held for this one cycle; hand priority over.
                    r_state <= S_IDLE;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ptr   <= ~r_sel;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_disp  <= 1'b0;
                    r_coin  <= 5'd0;
                end
            endcase
        end
    end

    assign v_item = r_item;
    assign v_coin = r_coin;
    assign v_disp = r_disp;
    assign gnt0   = r_gnt0;
    assign gnt1   = r_gnt1;
    assign busy   = r_busy;
    assign abort  = r_abort;

endmodule
